// File: rtl/frame_sync_pkg.sv
// Shared encodings and defaults for the frame synchroniser.
// No logic lives here.
package frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        PRESYNC = 2'b01,
        SYNC    = 2'b10
    } fs_state_e;

    localparam int FRAME_LEN_DEF = 16;
    localparam int CONFIRM_N_DEF = 2;
    localparam int MISS_N_DEF    = 3;
    localparam int LOSS_CNT_W    = 8;

endpackage

// File: rtl/frame_pos_cnt.sv
// Bit-position counter within a frame, with the marker check-cycle decode.
// Latency: position registered, next position exposed combinationally.
// No backpressure: advances every cycle unless held or loaded.
module frame_pos_cnt #(
    parameter  int FRAME_LEN = 16,
    localparam int POS_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             hold_i,
    output logic [POS_W-1:0] pos_o,
    output logic [POS_W-1:0] pos_d_o,
    output logic             check_o
);

    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;

    // A fresh marker is position 0, so the following cycle is position 1.
    always_comb begin
        pos_d = pos_q + POS_W'(1);
        if (load_i) begin
            pos_d = POS_W'(1);
        end else if (hold_i) begin
            pos_d = '0;
        end else if (pos_q == POS_W'(FRAME_LEN - 1)) begin
            pos_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o   = pos_q;
    assign pos_d_o = pos_d;
    assign check_o = (pos_q == '0);

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame lock FSM (HUNT/PRESYNC/SYNC) driven by an external 1010 detector; FRAME_SYNC_STATS_EN adds LOSS_CNT.
// Latency: FRAME_START/SYNC_LOST/DET_SCLR/PAYLOAD_VALID one cycle after the deciding edge.
// No backpressure: one serial bit consumed per clock.
module frame_sync_ctrl
    import frame_sync_pkg::*;
#(
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    parameter  int CONFIRM_N = CONFIRM_N_DEF,
    parameter  int MISS_N    = MISS_N_DEF,
    localparam int POS_W     = $clog2(FRAME_LEN)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_data_i,
    input  logic                  pdet_i,
    output logic                  det_sclr_o,
    output logic                  in_sync_o,
    output logic                  frame_start_o,
    output logic                  payload_valid_o,
    output logic                  payload_bit_o,
    output logic [POS_W-1:0]      bit_pos_o,
    output logic                  sync_lost_o,
    output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

    fs_state_e        state_q, state_d;
    logic [2:0]       conf_q, conf_d;
    logic [2:0]       miss_q, miss_d;
    logic             frame_start_q, frame_start_d;
    logic             sync_lost_q, sync_lost_d;
    logic             det_sclr_q;
    logic             payload_valid_q, payload_valid_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             check;

    frame_pos_cnt #(.FRAME_LEN(FRAME_LEN)) u_pos (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  ((state_q == HUNT) && pdet_i),
        .hold_i  (state_d == HUNT),
        .pos_o   (pos_q),
        .pos_d_o (pos_d),
        .check_o (check)
    );

    always_comb begin
        state_d       = state_q;
        conf_d        = conf_q;
        miss_d        = miss_q;
        frame_start_d = 1'b0;
        sync_lost_d   = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (pdet_i) begin
                    conf_d  = 3'd1;
                    miss_d  = 3'd0;
                    state_d = (CONFIRM_N == 1) ? SYNC : PRESYNC;
                end
            end
            PRESYNC: begin
                if (check && pdet_i) begin
                    conf_d = conf_q + 3'd1;
                    if (conf_q + 3'd1 >= 3'(CONFIRM_N)) state_d = SYNC;
                end else if (check) begin
                    state_d = HUNT;
                    conf_d  = 3'd0;
                    miss_d  = 3'd0;
                end
            end
            SYNC: begin
                if (check && pdet_i) begin
                    miss_d        = 3'd0;
                    frame_start_d = 1'b1;
                end else if (check && (miss_q + 3'd1 >= 3'(MISS_N))) begin
                    state_d     = HUNT;
                    conf_d      = 3'd0;
                    miss_d      = 3'd0;
                    sync_lost_d = 1'b1;
                end else if (check) begin
                    miss_d = miss_q + 3'd1;
                end
            end
            default: begin
                state_d = HUNT;
                conf_d  = 3'd0;
                miss_d  = 3'd0;
            end
        endcase
    end

    // Qualifier is built from next-state values so it lines up with BIT_POS.
    assign payload_valid_d = (state_d == SYNC) && (pos_d != '0)
                             && (pos_d <= POS_W'(FRAME_LEN - 4));

    // DET_SCLR resets high so the detector also sees a clear on the first edge out of reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= HUNT;
            conf_q          <= 3'd0;
            miss_q          <= 3'd0;
            frame_start_q   <= 1'b0;
            sync_lost_q     <= 1'b0;
            det_sclr_q      <= 1'b1;
            payload_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            conf_q          <= conf_d;
            miss_q          <= miss_d;
            frame_start_q   <= frame_start_d;
            sync_lost_q     <= sync_lost_d;
            det_sclr_q      <= sync_lost_d;
            payload_valid_q <= payload_valid_d;
        end
    end

`ifdef FRAME_SYNC_STATS_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            loss_cnt_q <= '0;
        end else if (sync_lost_d && (loss_cnt_q != '1)) begin
            loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`else
    assign loss_cnt_o = '0;
`endif

    assign in_sync_o       = (state_q == SYNC);
    assign frame_start_o   = frame_start_q;
    assign sync_lost_o     = sync_lost_q;
    assign det_sclr_o      = det_sclr_q;
    assign payload_valid_o = payload_valid_q;
    assign payload_bit_o   = in_data_i;
    assign bit_pos_o       = pos_q;

endmodule
